// File: rtl/mem_stream_reader_pkg.sv
// rtl/mem_stream_reader_pkg.sv - shared memory geometry and reader state type
package mem_pkg;

    localparam int MEM_WIDTH  = 32;
    localparam int MEM_ADDR_W = 7;
    localparam int MEM_DEPTH  = 128;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } reader_state_t;

endpackage

// File: rtl/mem_stream_reader_out_reg.sv
// rtl/mem_stream_reader_out_reg.sv - one-entry output register with valid/ready handshake
module stream_out_reg
    import mem_pkg::*;
#(
    parameter int WIDTH = MEM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             last_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    // Clear wins over load so an abort never leaves a word behind.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (clear_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
            last_d  = last_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - streams a wrapping address range out of the data memory (optional MEM_STREAM_READER_CHECKSUM_EN)
module mem_stream_reader
    import mem_pkg::*;
#(
    parameter int WIDTH  = MEM_WIDTH,
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] read_address,
    input  logic [WIDTH-1:0]  mem_data,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    output logic              out_last,
`ifdef MEM_STREAM_READER_CHECKSUM_EN
    output logic [WIDTH-1:0]  checksum,
`endif
    input  logic              out_ready
);

    localparam int CNT_W = ADDR_W + 1;

    reader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              done_q, done_d;

    logic fire;
    logic handshake;
    logic start_accept;

    assign handshake    = out_valid && out_ready;
    assign start_accept = (state_q == IDLE) && start;
    assign fire         = (state_q == RUN) && (rem_q != '0) && (!out_valid || out_ready) && !abort;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    // A zero length encodes a full sweep of the memory.
                    rem_d   = (length == '0) ? CNT_W'(1 << ADDR_W) : {1'b0, length};
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    rem_d   = '0;
                    state_d = IDLE;
                end else if (fire) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (abort) begin
                    rem_d   = '0;
                    state_d = IDLE;
                end else if (handshake && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    stream_out_reg #(
        .WIDTH(WIDTH)
    ) u_out (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (fire),
        .clear_i(abort),
        .data_i (mem_data),
        .last_i (rem_q == CNT_W'(1)),
        .ready_i(out_ready),
        .data_o (out_data),
        .valid_o(out_valid),
        .last_o (out_last)
    );

`ifdef MEM_STREAM_READER_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_accept)   checksum_d = '0;
        else if (handshake) checksum_d = checksum_q ^ out_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) checksum_q <= '0;
        else        checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`endif

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign read_address = addr_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - directed self-checking bench for mem_stream_reader
module tb_mem_stream_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  start_addr;
    logic [6:0]  length;
    logic        abort;
    logic        busy;
    logic        done;
    logic [6:0]  read_address;
    logic [31:0] mem_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] mem [0:127];
    int vectors = 0;
    int fails   = 0;

    assign mem_data = mem[read_address];

    mem_stream_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .length      (length),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .read_address(read_address),
        .mem_data    (mem_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] a, input logic [6:0] n);
        start      = 1'b1;
        start_addr = a;
        length     = n;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [0:9]  pat;
        logic [31:0] held_data;
        logic [6:0]  held_addr;
        logic        stalled;
        int          idx;
        int          done_cnt;

        for (int i = 0; i < 128; i++) mem[i] = 32'(i);
        rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; abort = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_addr", 32'(read_address), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic: 5..8, first valid two edges after the start strobe
        issue(7'd5, 7'd4);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_novalid", 32'(out_valid), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            check("basic_valid", 32'(out_valid), 32'd1);
            check("basic_data", out_data, 32'(5 + k));
            check("basic_last", 32'(out_last), 32'(k == 3));
            check("basic_nodone", 32'(done), 32'd0);
            step();
        end
        check("basic_done", 32'(done), 32'd1);
        check("basic_busy_end", 32'(busy), 32'd0);
        check("basic_valid_end", 32'(out_valid), 32'd0);
        step();
        check("basic_done_pulse", 32'(done), 32'd0);

        // Wrap with full length: 126,127,0..125
        issue(7'd126, 7'd0);
        step();
        for (int k = 0; k < 128; k++) begin
            check("wrap_data", out_data, 32'((126 + k) % 128));
            check("wrap_valid_busy", {30'd0, out_valid, busy}, 32'd3);
            if (k == 0 || k >= 126) check("wrap_last", 32'(out_last), 32'(k == 127));
            step();
        end
        check("wrap_done", 32'(done), 32'd1);
        step();

        // Back-pressure: ready pattern 1,0,0,1,0,1,0,0,1,1 then high
        pat = 10'b1001010011;
        idx = 0; done_cnt = 0; stalled = 1'b0; held_data = '0; held_addr = '0;
        issue(7'd20, 7'd3);
        for (int c = 0; c < 30; c++) begin
            if (out_valid) begin
                check("bp_data", out_data, 32'(20 + idx));
                check("bp_last", 32'(out_last), 32'(idx == 2));
                if (stalled) begin
                    check("bp_hold_data", out_data, held_data);
                    check("bp_hold_addr", 32'(read_address), 32'(held_addr));
                end
            end
            if (done) done_cnt++;
            out_ready = (c < 10) ? pat[c] : 1'b1;
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_addr = read_address;
            if (out_valid && out_ready) idx++;
            step();
        end
        out_ready = 1'b1;
        check("bp_count", 32'(idx), 32'd3);
        check("bp_done_once", 32'(done_cnt), 32'd1);

        // Abort after the third handshake
        issue(7'd40, 7'd10);
        step();
        step(); step(); step();
        check("abort_pre_data", out_data, 32'd43);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        step();
        check("abort_nodone", 32'(done), 32'd0);
        issue(7'd60, 7'd2);
        step();
        check("post_abort_d0", out_data, 32'd60);
        step();
        check("post_abort_d1", out_data, 32'd61);
        check("post_abort_last", 32'(out_last), 32'd1);
        step();
        check("post_abort_done", 32'(done), 32'd1);
        step();

        // Second start mid-transfer is ignored
        issue(7'd0, 7'd4);
        step();
        for (int k = 0; k < 4; k++) begin
            check("ign_data", out_data, 32'(k));
            check("ign_last", 32'(out_last), 32'(k == 3));
            start = (k == 1); start_addr = 7'd100; length = 7'd2;
            step();
        end
        start = 1'b0;
        check("ign_done", 32'(done), 32'd1);
        step();
        check("ign_idle", 32'(busy), 32'd0);

        // Asynchronous reset between edges
        issue(7'd10, 7'd8);
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", out_data, 32'd0);
        check("arst_addr", 32'(read_address), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("arst_idle_busy", 32'(busy), 32'd0);
        check("arst_idle_valid", 32'(out_valid), 32'd0);

`ifdef MEM_STREAM_READER_CHECKSUM_EN
        mem[30] = 32'hA5A5A5A5;
        mem[31] = 32'h0F0F0F0F;
        issue(7'd30, 7'd2);
        step(); step(); step();
        check("chk_done", 32'(done), 32'd1);
        check("chk_value", checksum, 32'hAAAAAAAA);
        step();
        check("chk_stable", checksum, 32'hAAAAAAAA);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
Downstream consumer of the 128x32 data memory. On a start command it walks a contiguous, wrapping address range through the memory's combinational read port. It presents each word on a valid/ready output stream with a one-entry output register, so back-pressure never loses or duplicates a word. It sits between the memory and the processing datapath that consumes stored operands.

Parameters:
- WIDTH, 32, data word width (matches the memory word).
- ADDR_W, 7, address width; the memory depth is 2**ADDR_W = 128.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle command strobe; accepted only in IDLE.
- start_addr  input  ADDR_W  first address to read.
- length  input  ADDR_W  number of words to read; 0 encodes 128.
- abort  input  1  terminate the current transfer.
- busy  output  1  high from the cycle after start is accepted until the final word handshake or an abort.
- done  output  1  one-cycle pulse in the cycle after the final handshake.
- read_address  output  ADDR_W  drives the memory read address.
- mem_data  input  WIDTH  memory read data, combinational from read_address.
- out_data  output  WIDTH  stream data.
- out_valid  output  1  stream valid.
- out_last  output  1  marks the final word of the transfer.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, out_valid, out_last = 0; out_data = 0; read_address = 0; internal counters = 0.
- States:
  - IDLE: start=1 → load addr=start_addr, remaining=(length==0 ? 128 : length) using an 8-bit counter → RUN.
  - RUN: issue reads while remaining>0.
  - FLUSH: all words captured; wait for the last handshake → IDLE, with done=1 for one cycle.
- Capture rule in RUN: fire = (remaining>0) && (!out_valid || out_ready). On fire:
  - out_data <= mem_data at read_address=addr.
  - out_valid <= 1; out_last <= (remaining==1).
  - addr <= addr+1, wrapping 127→0 modulo 2**ADDR_W.
  - remaining <= remaining-1.
- If out_valid && out_ready && no fire, then out_valid <= 0.
- Throughput: one word per cycle with out_ready held high. First out_valid appears 2 cycles after the start strobe (1 cycle to enter RUN, 1 cycle to capture).
- read_address is registered state (addr); it holds its value while stalled and in IDLE.
- Back-pressure: while out_valid && !out_ready, out_data and out_last stay stable and addr does not advance.
- Transition to FLUSH occurs on the fire that captures the word with out_last=1. FLUSH exits on out_valid && out_ready && out_last.
- start while busy: ignored, no effect. A start in the same cycle as the done pulse is accepted, because the FSM is already in IDLE.
- abort: takes effect in any state at the next edge. It overrides fire: out_valid=0, out_last=0, busy=0, state=IDLE, and done is not pulsed. abort in IDLE is a no-op.
- The transfer wrap covers start_addr=120, length=16 → addresses 120..127, 0..7.

Optional Feature:
- Macro: MEM_STREAM_READER_CHECKSUM_EN.
- With the macro defined: adds output port checksum [WIDTH-1:0].
  - The checksum is the XOR of every word accepted by a handshake in the current transfer.
  - It clears to 0 when start is accepted and on reset.
  - It is valid and stable from the done pulse until the next accepted start.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_pkg:
  - MEM_WIDTH=32, MEM_ADDR_W=7, MEM_DEPTH=128.
  - State enum type reader_state_t {IDLE, RUN, FLUSH}.
- Sub-module: the output register and handshake logic (load/hold/drain of out_data, out_valid, out_last) is a single natural sub-module, stream_out_reg. The FSM and address/count logic stay in the top.

Test Plan:
- Basic: memory preloaded with mem[i]=i; start_addr=5, length=4, out_ready=1 → words 5,6,7,8 on consecutive cycles; out_last only on 8; done pulses once; first out_valid 2 cycles after start.
- Wrap/full length: start_addr=126, length=0 → 128 words 126,127,0,1,…,125; out_last on 125; busy high throughout.
- Back-pressure: length=3, out_ready toggled 1,0,0,1,0,1… → every word is delivered exactly once in order; out_data stays stable while stalled; read_address does not advance while stalled.
- Abort mid-transfer: length=10, abort after the 3rd handshake → out_valid=0 and busy=0 next cycle; no done pulse; a fresh start then reads correctly.
- Reset mid-RUN: assert rst_n=0 asynchronously between edges → all outputs go to 0 immediately; state is IDLE after release.
- Ignored start / checksum: a second start mid-transfer has no effect. With MEM_STREAM_READER_CHECKSUM_EN and words A5A5A5A5, 0F0F0F0F → checksum=AAAAAAAA at done.
